// File: rtl/glb_stream_sink.sv
// glb_stream_sink: captures a 16-bit valid/ready stream into a local buffer.
// Counts words up to TX_SIZE, raises done, flags overrun; registered read-back.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start             one-cycle pulse arming a run (IDLE/DONE only)
//   data, valid       producer payload and valid
//   ready             registered accept, optionally throttled every STALL_EVERY words
//   done, count       run complete flag, words accepted in this run
//   overrun           sticky: valid seen while DONE
//   rd_addr, rd_data  read-back port, one-cycle latency
module glb_stream_sink #(
    parameter int TX_SIZE     = 32,
    parameter int DEPTH       = 1024,
    parameter int ADDR_W      = 10,
    parameter int STALL_EVERY = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [15:0]       data,
    input  logic              valid,
    output logic              ready,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic              overrun,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [15:0]       rd_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic            ready_q, ready_d;
    logic            done_q, done_d;
    logic            overrun_q, overrun_d;
    logic [ADDR_W:0] count_q, count_d;
    logic [ADDR_W:0] stall_q, stall_d;
    logic [15:0]     rd_data_q;
    logic [15:0]     mem_q [DEPTH];

    logic xfer;
    logic last;
    logic stall_hit;

    // ready_q is only ever high in RECV, but gating on state keeps the
    // write enable obviously confined to a live run.
    assign xfer      = valid && ready_q && (state_q == S_RECV);
    assign last      = (int'(count_q) == TX_SIZE - 1);
    assign stall_hit = (STALL_EVERY != 0) &&
                       (int'(stall_q) + 1 == STALL_EVERY);

    always_comb begin
        state_d   = state_q;
        ready_d   = ready_q;
        done_d    = done_q;
        overrun_d = overrun_q;
        count_d   = count_q;
        stall_d   = stall_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (state_q == S_DONE && valid) begin
                    overrun_d = 1'b1;
                end
                if (start) begin
                    count_d   = '0;
                    stall_d   = '0;
                    overrun_d = 1'b0;
                    if (TX_SIZE == 0) begin
                        state_d = S_DONE;
                        ready_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RECV;
                        ready_d = 1'b1;
                        done_d  = 1'b0;
                    end
                end
            end
            S_RECV: begin
                if (xfer) begin
                    count_d = count_q + 1'b1;
                    if (last) begin
                        // final word: no stall cycle, straight to DONE
                        state_d = S_DONE;
                        ready_d = 1'b0;
                        done_d  = 1'b1;
                    end else if (stall_hit) begin
                        stall_d = '0;
                        ready_d = 1'b0;
                    end else begin
                        stall_d = stall_q + 1'b1;
                        ready_d = 1'b1;
                    end
                end else begin
                    // a stall lasts exactly one cycle
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            count_q   <= '0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            count_q   <= count_d;
            stall_q   <= stall_d;
        end
    end

    // Buffer survives reset; a reset edge suppresses any write.
    always_ff @(posedge clk) begin
        if (xfer && !reset) begin
            mem_q[count_q[ADDR_W-1:0]] <= data;
        end
    end

    // Read-before-write: a same-edge write shows up on the next read.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (int'(rd_addr) < DEPTH) begin
            rd_data_q <= mem_q[rd_addr];
        end else begin
            rd_data_q <= '0;
        end
    end

    assign ready   = ready_q;
    assign done    = done_q;
    assign overrun = overrun_q;
    assign count   = count_q;
    assign rd_data = rd_data_q;

endmodule

// File: tb/tb_glb_stream_sink.sv
// tb_glb_stream_sink: randomized self-checking bench for glb_stream_sink.
// Three builds: default, TX_SIZE=8/STALL_EVERY=4, TX_SIZE=0.
module tb_glb_stream_sink;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // build A: TX_SIZE=32, no stall
    logic        a_start = 0, a_valid = 0;
    logic [15:0] a_data = 0;
    logic [9:0]  a_rd_addr = 0;
    logic        a_ready, a_done, a_overrun;
    logic [10:0] a_count;
    logic [15:0] a_rd_data;

    // build B: TX_SIZE=8, STALL_EVERY=4
    logic        b_start = 0, b_valid = 0;
    logic [15:0] b_data = 0;
    logic [9:0]  b_rd_addr = 0;
    logic        b_ready, b_done, b_overrun;
    logic [10:0] b_count;
    logic [15:0] b_rd_data;

    // build C: TX_SIZE=0
    logic        c_start = 0, c_valid = 0;
    logic [15:0] c_data = 0;
    logic [9:0]  c_rd_addr = 0;
    logic        c_ready, c_done, c_overrun;
    logic [10:0] c_count;
    logic [15:0] c_rd_data;

    glb_stream_sink #(.TX_SIZE(32), .STALL_EVERY(0)) u_a (
        .clk(clk), .reset(reset), .start(a_start), .data(a_data),
        .valid(a_valid), .ready(a_ready), .done(a_done), .count(a_count),
        .overrun(a_overrun), .rd_addr(a_rd_addr), .rd_data(a_rd_data)
    );

    glb_stream_sink #(.TX_SIZE(8), .STALL_EVERY(4)) u_b (
        .clk(clk), .reset(reset), .start(b_start), .data(b_data),
        .valid(b_valid), .ready(b_ready), .done(b_done), .count(b_count),
        .overrun(b_overrun), .rd_addr(b_rd_addr), .rd_data(b_rd_data)
    );

    glb_stream_sink #(.TX_SIZE(0), .STALL_EVERY(0)) u_c (
        .clk(clk), .reset(reset), .start(c_start), .data(c_data),
        .valid(c_valid), .ready(c_ready), .done(c_done), .count(c_count),
        .overrun(c_overrun), .rd_addr(c_rd_addr), .rd_data(c_rd_data)
    );

    // model of build A's buffer
    logic [15:0] a_mem [32];
    bit          a_known [32];
    logic [15:0] b_mem [8];

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One run on build A; pct = valid probability, stop = words to send.
    task automatic run_a(input int pct, input bit incr, input bit poke,
                         input int stop, output int edges);
        int n;
        int e;
        logic [15:0] w;
        logic [15:0] oldv;
        bit kn;
        bit v;
        n = 0;
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        e = 1;
        while (n < 32 && n < stop && e < 400) begin
            v = ($urandom_range(99) < pct);
            w = incr ? 16'(n) : 16'($urandom);
            a_valid   = v;
            a_data    = w;
            a_start   = poke && ($urandom_range(7) == 0);
            a_rd_addr = 10'(n);
            kn   = a_known[n];
            oldv = a_mem[n];
            checks++;
            if (a_ready !== 1'b1) begin
                errors++;
                $display("FAIL run_ready got %b exp 1 at word %0d", a_ready, n);
            end
            checks++;
            if (a_count !== 11'(n) || a_done !== 1'b0) begin
                errors++;
                $display("FAIL run_count got %0d/done %b exp %0d/0",
                         a_count, a_done, n);
            end
            step();
            e++;
            if (kn) begin
                checks++;
                if (a_rd_data !== oldv) begin
                    errors++;
                    $display("FAIL rd_old got %h exp %h addr %0d",
                             a_rd_data, oldv, n);
                end
            end
            if (v) begin
                a_mem[n]   = w;
                a_known[n] = 1'b1;
                n++;
            end
        end
        a_valid = 1'b0;
        a_start = 1'b0;
        if (e >= 400) begin
            errors++;
            $display("FAIL run_timeout got %0d words exp %0d", n, stop);
        end
        edges = e;
    endtask

    task automatic readback_a(input int n);
        for (int i = 0; i < n; i++) begin
            a_rd_addr = 10'(i);
            step();
            checks++;
            if (a_rd_data !== a_mem[i]) begin
                errors++;
                $display("FAIL readback_a got %h exp %h addr %0d",
                         a_rd_data, a_mem[i], i);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if ({a_ready, a_done, a_overrun, a_count, a_rd_data} !== '0 ||
            {b_ready, b_done, b_overrun, b_count, b_rd_data} !== '0 ||
            {c_ready, c_done, c_overrun, c_count, c_rd_data} !== '0) begin
            errors++;
            $display("FAIL reset_vals got a=%b%b%b%0d b=%b%b%b%0d exp zeros",
                     a_ready, a_done, a_overrun, a_count,
                     b_ready, b_done, b_overrun, b_count);
        end
        reset = 1'b0;
        step();
        checks++;
        if (a_ready !== 1'b0 || a_done !== 1'b0 || c_done !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold got r%b d%b cd%b exp 000",
                     a_ready, a_done, c_done);
        end
    endtask

    task automatic test_full_run();
        int e;
        run_a(100, 1'b1, 1'b0, 32, e);
        checks++;
        if (e !== 33 || a_done !== 1'b1) begin
            errors++;
            $display("FAIL full_latency got %0d done %b exp 33 done 1", e, a_done);
        end
        checks++;
        if (a_count !== 11'd32 || a_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_count got %0d rdy %b exp 32 rdy 0",
                     a_count, a_ready);
        end
        readback_a(32);
    endtask

    task automatic test_overrun();
        checks++;
        if (a_overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_pre got %b exp 0", a_overrun);
        end
        a_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_data = 16'($urandom);
            step();
            checks++;
            if (a_overrun !== 1'b1 || a_count !== 11'd32 ||
                a_done !== 1'b1 || a_ready !== 1'b0) begin
                errors++;
                $display("FAIL overrun got ov%b cnt%0d d%b r%b exp 1 32 1 0",
                         a_overrun, a_count, a_done, a_ready);
            end
        end
        a_valid = 1'b0;
        readback_a(32);
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        checks++;
        if (a_overrun !== 1'b0 || a_done !== 1'b0 ||
            a_ready !== 1'b1 || a_count !== 11'd0) begin
            errors++;
            $display("FAIL rearm got ov%b d%b r%b cnt%0d exp 0 0 1 0",
                     a_overrun, a_done, a_ready, a_count);
        end
    endtask

    task automatic test_random_valid();
        int e;
        run_a(55, 1'b0, 1'b1, 32, e);
        checks++;
        if (a_done !== 1'b1 || a_count !== 11'd32) begin
            errors++;
            $display("FAIL rand_end got d%b cnt%0d exp 1 32", a_done, a_count);
        end
        readback_a(32);
    endtask

    task automatic test_reset_mid_run();
        int e;
        run_a(100, 1'b0, 1'b0, 10, e);
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (a_ready !== 1'b0 || a_count !== 11'd0 ||
            a_done !== 1'b0 || a_rd_data !== 16'h0) begin
            errors++;
            $display("FAIL mid_reset got r%b cnt%0d d%b rd%h exp 0 0 0 0",
                     a_ready, a_count, a_done, a_rd_data);
        end
        readback_a(10);
        run_a(80, 1'b0, 1'b0, 32, e);
        checks++;
        if (a_done !== 1'b1 || a_count !== 11'd32) begin
            errors++;
            $display("FAIL post_reset got d%b cnt%0d exp 1 32", a_done, a_count);
        end
        readback_a(32);
    endtask

    task automatic test_stall();
        bit sched[$];
        int n;
        int e;
        logic [15:0] w;
        // expected ready per cycle: one idle after every 4th word but the last
        for (int k = 0; k < 8; k++) begin
            sched.push_back(1'b1);
            if ((k + 1) % 4 == 0 && k + 1 < 8) sched.push_back(1'b0);
        end
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        b_valid = 1'b1;
        e = 1;
        n = 0;
        foreach (sched[k]) begin
            w = 16'($urandom);
            b_data = w;
            checks++;
            if (b_ready !== sched[k] || b_done !== 1'b0) begin
                errors++;
                $display("FAIL stall_ready got r%b d%b exp r%b d0 cyc %0d",
                         b_ready, b_done, sched[k], k);
            end
            step();
            e++;
            if (sched[k]) begin
                b_mem[n] = w;
                n++;
            end
        end
        b_valid = 1'b0;
        checks++;
        if (e !== 10 || b_done !== 1'b1 || b_count !== 11'd8 ||
            b_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_done got e%0d d%b cnt%0d r%b exp 10 1 8 0",
                     e, b_done, b_count, b_ready);
        end
        for (int i = 0; i < 8; i++) begin
            b_rd_addr = 10'(i);
            step();
            checks++;
            if (b_rd_data !== b_mem[i]) begin
                errors++;
                $display("FAIL readback_b got %h exp %h addr %0d",
                         b_rd_data, b_mem[i], i);
            end
        end
    endtask

    task automatic test_tx_zero();
        c_start = 1'b1;
        step();
        c_start = 1'b0;
        checks++;
        if (c_done !== 1'b1 || c_ready !== 1'b0 || c_overrun !== 1'b0) begin
            errors++;
            $display("FAIL zero_done got d%b r%b ov%b exp 1 0 0",
                     c_done, c_ready, c_overrun);
        end
        c_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            c_data = 16'($urandom);
            step();
            checks++;
            if (c_ready !== 1'b0 || c_count !== 11'd0 || c_done !== 1'b1) begin
                errors++;
                $display("FAIL zero_hold got r%b cnt%0d d%b exp 0 0 1",
                         c_ready, c_count, c_done);
            end
        end
        c_valid = 1'b0;
        checks++;
        if (c_overrun !== 1'b1) begin
            errors++;
            $display("FAIL zero_overrun got %b exp 1", c_overrun);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            a_known[i] = 1'b0;
            a_mem[i]   = 16'h0;
        end
        @(negedge clk);
        test_reset();
        test_full_run();
        test_overrun();
        test_random_valid();
        test_reset_mid_run();
        test_stall();
        test_tx_zero();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/glb_stream_sink.md
# glb_stream_sink

Synthesizable capture stage that sits directly downstream of the global-buffer write stream feeding a memory-core tile. It accepts a 16-bit valid/ready stream and stores each accepted word in order into a local buffer. It counts transfers up to a programmed total and asserts `done` when the total is reached. An optional periodic back-pressure pattern exercises the producer's stall handling. A registered read-back port lets the checker compare captured data against the golden file.

## Interface
Parameters:
- `TX_SIZE`, 32: number of words to accept per run; must be 0..`DEPTH`.
- `DEPTH`, 1024: buffer entries.
- `ADDR_W`, 10: buffer address width; `2**ADDR_W` ≥ `DEPTH`.
- `STALL_EVERY`, 0: 0 = no back-pressure; N>0 = drop `ready` for exactly one cycle after every N accepted words.

Ports:
- `clk` in 1: clock; all logic on posedge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse that arms a run; honoured in IDLE and DONE, ignored in RECV.
- `data` in 16: stream payload.
- `valid` in 1: producer has a word on `data`.
- `ready` out 1: sink accepts; registered output, with no combinational path from `valid`.
- `done` out 1: run complete; held high until the next `start` or `reset`.
- `count` out `ADDR_W`+1: words accepted in the current run.
- `overrun` out 1: sticky; set when `valid`=1 in DONE; cleared by `start` or `reset`.
- `rd_addr` in `ADDR_W`: read-back address.
- `rd_data` out 16: `buf[rd_addr]`, one-cycle registered latency.

## Operation
- Handshake: a word transfers on a posedge where `valid`=1 and `ready`=1. On transfer, `buf[count]` <= `data` and `count` <= `count`+1.
- States:
  - IDLE: reset state; `ready`=0, `done`=0. `start` moves to RECV, clears `count`, `overrun` and the stall counter.
  - IDLE with `TX_SIZE`=0: `start` moves straight to DONE. `ready` never rises.
  - RECV: `ready`=1 except on stall cycles. A transfer with `count`=`TX_SIZE`-1 moves to DONE. On that same edge `ready` <= 0 and `done` <= 1.
  - DONE: `ready`=0, `done`=1. `valid`=1 sets `overrun`. `start` re-arms exactly as from IDLE, and `done` falls.
- Stall: a stall counter increments on each transfer. When it reaches `STALL_EVERY`, it resets to 0 and `ready` is 0 for the following cycle only, then returns to 1. No stall cycle is inserted after the final word.
- `start` during RECV is ignored; `count` and buffer contents are unaffected.
- Buffer contents are not cleared by `reset` or `start`. Read-back is valid in any state.
- `count` saturates at `TX_SIZE` and never wraps. Buffer writes never go beyond index `TX_SIZE`-1.

## Timing
- Reset values: `ready`=0, `done`=0, `count`=0, `overrun`=0, `rd_data`=0, state IDLE.
- `start` sampled at edge E → `ready`=1 after E, so the first transfer is possible at E+1.
- With `STALL_EVERY`=0 and `valid` held high, `TX_SIZE` words transfer on TX_SIZE consecutive edges. `done` is high after the last transfer edge, giving a latency of TX_SIZE+1 cycles from `start`.
- With `STALL_EVERY`=N, each N accepted words are followed by one idle cycle, except after the final word.
- `rd_data` updates one edge after `rd_addr`. If `rd_addr` equals the address being written on the same edge, `rd_data` returns the old contents; the new value is visible on the next read.
- `reset` mid-run: state returns to IDLE on that edge and all outputs go to their reset values. The partial buffer contents remain.

## Test plan
- Reset, `start`, then 32 words 0x0000..0x001F with `valid` held high → `done` rises 33 cycles after `start`; `count`=32; read-back of addresses 0..31 matches the written data.
- `STALL_EVERY`=4, `TX_SIZE`=8, `valid` continuous → `ready` low exactly once, after the 4th word; `done` after 10 cycles.
- Producer drops `valid` on random cycles → no transfer occurs on those cycles; data order is preserved and `count` matches the number of handshakes.
- After `done`, hold `valid`=1 for 3 cycles → `overrun`=1, `count` stays 32, buffer is unchanged. A subsequent `start` clears `overrun` and `done`.
- `reset` asserted after 10 of 32 words → `ready`=0, `count`=0 on the next cycle; a new `start` captures 32 words from address 0.
- `TX_SIZE`=0 build: `start` → `done`=1 the next cycle and `ready` never asserts.
